// File: rtl/sdram_arbiter_if.sv
// Client and SDRAM-controller signal bundle for sdram_arbiter.
// The arbiter takes the slave view; clients plus controller take master.
interface sdram_arbiter_if #(
  parameter int ADDR_W = 22
);
  logic [2:0]          req;
  logic [2:0]          we;
  logic [3*ADDR_W-1:0] addr;
  logic [47:0]         wdata;
  logic [5:0]          mask;
  logic [2:0]          ack;
  logic [15:0]         rdata;
  logic                busy;
  logic                err;
  logic                mem_req;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [15:0]         mem_wdata;
  logic [1:0]          mem_dqm;
  logic                mem_accept;
  logic                mem_done;
  logic [15:0]         mem_rdata;

  modport slave (
    input  req, we, addr, wdata, mask,
    input  mem_accept, mem_done, mem_rdata,
    output ack, rdata, busy, err,
    output mem_req, mem_we, mem_addr,
    output mem_wdata, mem_dqm
  );

  modport master (
    output req, we, addr, wdata, mask,
    output mem_accept, mem_done, mem_rdata,
    input  ack, rdata, busy, err,
    input  mem_req, mem_we, mem_addr,
    input  mem_wdata, mem_dqm
  );
endinterface

// File: rtl/sdram_arbiter.sv
// Three-way SDRAM command port arbiter: fixed priority r0>r1>r2,
// starvation boost for r1/r2, one transaction at a time, with timeout.
module sdram_arbiter #(
  parameter int ADDR_W     = 22,
  parameter int STARVE_LIM = 8,
  parameter int TIMEOUT    = 255
) (
  input  logic           m_clock,
  input  logic           p_reset,
  sdram_arbiter_if.slave bus
);
  localparam int SW = $clog2(STARVE_LIM + 1);
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [SW-1:0] SMAX = '1;

  typedef enum logic [1:0] {
    IDLE, ISSUE, WAIT, DONE
  } state_t;

  state_t        state, state_n;
  logic [1:0]    g, win;
  logic [SW-1:0] starve1, starve2;
  logic [TW-1:0] tcnt;
  logic          boost1, boost2;
  logic          grant, fin, expire, t_hit;

  always_comb begin
    boost2 = bus.req[2] && (starve2 >= SW'(STARVE_LIM));
    boost1 = bus.req[1] && (starve1 >= SW'(STARVE_LIM));
    win = 2'd0;
    if (boost2)          win = 2'd2;
    else if (boost1)     win = 2'd1;
    else if (bus.req[0]) win = 2'd0;
    else if (bus.req[1]) win = 2'd1;
    else if (bus.req[2]) win = 2'd2;
  end

  assign t_hit = (TIMEOUT != 0) && (tcnt == TW'(TIMEOUT));

  always_ff @(posedge m_clock) begin
    if (p_reset) state <= IDLE;
    else         state <= state_n;
  end

  // A real completion wins over a timeout landing on the same cycle.
  always_comb begin
    state_n = state;
    grant   = 1'b0;
    fin     = 1'b0;
    expire  = 1'b0;
    unique case (state)
      IDLE: begin
        if (|bus.req) begin
          grant   = 1'b1;
          state_n = ISSUE;
        end
      end
      ISSUE: begin
        if (bus.mem_accept && bus.mem_done) begin
          fin     = 1'b1;
          state_n = DONE;
        end else if (t_hit) begin
          expire  = 1'b1;
          state_n = DONE;
        end else if (bus.mem_accept) begin
          state_n = WAIT;
        end
      end
      WAIT: begin
        if (bus.mem_done) begin
          fin     = 1'b1;
          state_n = DONE;
        end else if (t_hit) begin
          expire  = 1'b1;
          state_n = DONE;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge m_clock) begin
    if (p_reset) begin
      g             <= 2'd0;
      starve1       <= '0;
      starve2       <= '0;
      tcnt          <= '0;
      bus.rdata     <= 16'h0;
      bus.err       <= 1'b0;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= 16'h0;
      bus.mem_dqm   <= 2'b11;
    end else begin
      if (state == IDLE) begin
        if (!bus.req[1] || win == 2'd1) starve1 <= '0;
        else if (starve1 != SMAX)       starve1 <= starve1 + 1'b1;
        if (!bus.req[2] || win == 2'd2) starve2 <= '0;
        else if (starve2 != SMAX)       starve2 <= starve2 + 1'b1;
      end
      // tcnt holds the number of cycles spent in ISSUE+WAIT so far.
      if (grant) begin
        g             <= win;
        tcnt          <= TW'(1);
        bus.mem_req   <= 1'b1;
        bus.mem_we    <= bus.we[win];
        bus.mem_addr  <= bus.addr[int'(win)*ADDR_W +: ADDR_W];
        bus.mem_wdata <= bus.wdata[int'(win)*16 +: 16];
        bus.mem_dqm   <= bus.mask[int'(win)*2 +: 2];
      end else if (state == ISSUE || state == WAIT) begin
        tcnt <= tcnt + TW'(1);
      end
      if (state == ISSUE && bus.mem_accept) bus.mem_req <= 1'b0;
      if (fin && !bus.mem_we) bus.rdata <= bus.mem_rdata;
      if (expire) begin
        bus.mem_req <= 1'b0;
        bus.rdata   <= 16'h0;
        bus.err     <= 1'b1;
      end
    end
  end

  assign bus.ack  = (state == DONE) ? (3'd1 << g) : 3'd0;
  assign bus.busy = (state != IDLE);
endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: default build plus a TIMEOUT=16 build
// sharing clock and reset; the bench plays both clients and controller.
module tb_sdram_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  sdram_arbiter_if #(.ADDR_W(22)) bus ();
  sdram_arbiter_if #(.ADDR_W(22)) bus_t ();

  sdram_arbiter #(
    .ADDR_W(22), .STARVE_LIM(8), .TIMEOUT(255)
  ) dut (
    .m_clock(clk), .p_reset(rst), .bus(bus)
  );

  sdram_arbiter #(
    .ADDR_W(22), .STARVE_LIM(8), .TIMEOUT(16)
  ) dut_t (
    .m_clock(clk), .p_reset(rst), .bus(bus_t)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.req = 3'b0;   bus.we = 3'b0;
    bus.addr = '0;    bus.wdata = '0;
    bus.mask = '0;    bus.mem_accept = 1'b0;
    bus.mem_done = 1'b0; bus.mem_rdata = 16'h0;
    bus_t.req = 3'b0; bus_t.we = 3'b0;
    bus_t.addr = '0;  bus_t.wdata = '0;
    bus_t.mask = '0;  bus_t.mem_accept = 1'b0;
    bus_t.mem_done = 1'b0; bus_t.mem_rdata = 16'h0;
  endtask

  // Drives one transaction on bus with immediate accept and done;
  // the arbiter must be IDLE with req already set on entry.
  task automatic serve_one(input logic [15:0] rd,
                           output logic [2:0] a);
    tick();
    bus.mem_accept = 1'b1;
    tick();
    bus.mem_accept = 1'b0;
    bus.mem_done   = 1'b1;
    bus.mem_rdata  = rd;
    tick();
    bus.mem_done = 1'b0;
    a = bus.ack;
    tick();
  endtask

  task automatic test_reset();
    clear_inputs();
    bus.req = 3'b111;
    rst = 1'b1;
    tick();
    tick();
    n_cmp++;
    if ({bus.busy, bus.err, bus.ack} !== 5'b0) begin
      n_bad++;
      $display("FAIL reset_status: got %b want 00000",
               {bus.busy, bus.err, bus.ack});
    end
    n_cmp++;
    if ({bus.mem_req, bus.mem_we, bus.mem_dqm} !== 4'b0011) begin
      n_bad++;
      $display("FAIL reset_cmd: got %b want 0011",
               {bus.mem_req, bus.mem_we, bus.mem_dqm});
    end
    n_cmp++;
    if ({bus.mem_addr, bus.mem_wdata, bus.rdata} !== 54'h0) begin
      n_bad++;
      $display("FAIL reset_data: got %h want 0",
               {bus.mem_addr, bus.mem_wdata, bus.rdata});
    end
    n_cmp++;
    if ({bus_t.err, bus_t.busy, bus_t.mem_dqm} !== 4'b0011) begin
      n_bad++;
      $display("FAIL reset_t: got %b want 0011",
               {bus_t.err, bus_t.busy, bus_t.mem_dqm});
    end
    bus.req = 3'b0;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_read();
    bus.we = 3'b000;
    bus.addr[22 +: 22] = 22'h00123;
    bus.req = 3'b010;
    tick();
    n_cmp++;
    if ({bus.mem_req, bus.mem_we, bus.busy, bus.mem_addr}
        !== {3'b101, 22'h00123}) begin
      n_bad++;
      $display("FAIL t1_issue: got req/we/busy/addr %b%b%b %h want 101 00123",
               bus.mem_req, bus.mem_we, bus.busy, bus.mem_addr);
    end
    bus.mem_accept = 1'b1;
    tick();
    bus.mem_accept = 1'b0;
    n_cmp++;
    if ({bus.mem_req, bus.ack} !== 4'b0000) begin
      n_bad++;
      $display("FAIL t1_wait: got req/ack %b want 0000",
               {bus.mem_req, bus.ack});
    end
    bus.mem_done  = 1'b1;
    bus.mem_rdata = 16'hBEEF;
    tick();
    bus.mem_done = 1'b0;
    n_cmp++;
    if ({bus.ack, bus.rdata} !== {3'b010, 16'hBEEF}) begin
      n_bad++;
      $display("FAIL t1_ack: got ack %b rdata %h want 010 beef",
               bus.ack, bus.rdata);
    end
    bus.req = 3'b0;
    tick();
    n_cmp++;
    if ({bus.ack, bus.busy} !== 4'b0000) begin
      n_bad++;
      $display("FAIL t1_idle: got ack/busy %b want 0000",
               {bus.ack, bus.busy});
    end
  endtask

  task automatic test_contention();
    logic [2:0] exp [11];
    logic [2:0] a;
    exp = '{3'b001, 3'b001, 3'b001, 3'b001,
            3'b001, 3'b001, 3'b001, 3'b001,
            3'b100, 3'b010, 3'b001};
    bus.addr = '0;
    bus.req  = 3'b111;
    for (int i = 0; i < 11; i++) begin
      serve_one(16'h1000 + 16'(i), a);
      n_cmp++;
      if (a !== exp[i]) begin
        n_bad++;
        $display("FAIL t2_grant%0d: got ack %b want %b", i, a, exp[i]);
      end
    end
    bus.req = 3'b0;
    tick();
  endtask

  task automatic test_write_mask();
    bus.we = 3'b100;
    bus.addr[44 +: 22] = 22'h3FFFFF;
    bus.wdata[32 +: 16] = 16'h5AA5;
    bus.mask = 6'b10_00_00;
    bus.req = 3'b100;
    tick();
    n_cmp++;
    if ({bus.mem_req, bus.mem_we, bus.mem_dqm,
         bus.mem_addr, bus.mem_wdata}
        !== {1'b1, 1'b1, 2'b10, 22'h3FFFFF, 16'h5AA5}) begin
      n_bad++;
      $display("FAIL t3_cmd: got %b %b %b %h %h want 1 1 10 3fffff 5aa5",
               bus.mem_req, bus.mem_we, bus.mem_dqm,
               bus.mem_addr, bus.mem_wdata);
    end
    bus.mem_accept = 1'b1;
    tick();
    bus.mem_accept = 1'b0;
    bus.mem_done   = 1'b1;
    bus.mem_rdata  = 16'hDEAD;
    tick();
    bus.mem_done = 1'b0;
    n_cmp++;
    if ({bus.ack, bus.rdata} !== {3'b100, 16'h100A}) begin
      n_bad++;
      $display("FAIL t3_ack: got ack %b rdata %h want 100 100a",
               bus.ack, bus.rdata);
    end
    bus.req = 3'b0;
    bus.we = 3'b0;
    bus.mask = 6'b0;
    bus.wdata = '0;
    tick();
  endtask

  task automatic test_accept_done_same();
    bus.addr[22 +: 22] = 22'h00777;
    bus.req = 3'b010;
    tick();
    bus.mem_accept = 1'b1;
    bus.mem_done   = 1'b1;
    bus.mem_rdata  = 16'h7777;
    tick();
    bus.mem_accept = 1'b0;
    bus.mem_done   = 1'b0;
    n_cmp++;
    if ({bus.ack, bus.rdata} !== {3'b010, 16'h7777}) begin
      n_bad++;
      $display("FAIL same_cycle_ack: got ack %b rdata %h want 010 7777",
               bus.ack, bus.rdata);
    end
    bus.req = 3'b0;
    tick();
    n_cmp++;
    if (bus.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL same_cycle_idle: got busy %b want 0", bus.busy);
    end
  endtask

  task automatic test_accept_stall();
    bus.addr = '0;
    bus.addr[0 +: 22] = 22'h00042;
    bus.mask = 6'b00_00_01;
    bus.req = 3'b001;
    tick();
    bus.req = 3'b000;
    for (int i = 0; i < 10; i++) begin
      n_cmp++;
      if ({bus.mem_req, bus.mem_we, bus.mem_dqm, bus.mem_addr,
           bus.mem_wdata, bus.ack}
          !== {1'b1, 1'b0, 2'b01, 22'h00042, 16'h0, 3'b0}) begin
        n_bad++;
        $display("FAIL t4_hold%0d: got %b %b %b %h %h %b want 1 0 01 42 0 0",
                 i, bus.mem_req, bus.mem_we, bus.mem_dqm,
                 bus.mem_addr, bus.mem_wdata, bus.ack);
      end
      tick();
    end
    bus.mem_accept = 1'b1;
    tick();
    bus.mem_accept = 1'b0;
    n_cmp++;
    if ({bus.mem_req, bus.busy, bus.ack} !== 5'b01000) begin
      n_bad++;
      $display("FAIL t4_accepted: got %b want 01000",
               {bus.mem_req, bus.busy, bus.ack});
    end
    tick();
    n_cmp++;
    if (bus.ack !== 3'b0) begin
      n_bad++;
      $display("FAIL t4_wait: got ack %b want 000", bus.ack);
    end
    bus.mem_done  = 1'b1;
    bus.mem_rdata = 16'h1234;
    tick();
    bus.mem_done = 1'b0;
    n_cmp++;
    if ({bus.ack, bus.rdata} !== {3'b001, 16'h1234}) begin
      n_bad++;
      $display("FAIL t4_ack: got ack %b rdata %h want 001 1234",
               bus.ack, bus.rdata);
    end
    bus.mask = 6'b0;
    tick();
    n_cmp++;
    if (bus.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL t4_idle: got busy %b want 0", bus.busy);
    end
  endtask

  task automatic test_timeout();
    int   k;
    logic got;
    bus_t.req = 3'b001;
    tick();
    bus_t.mem_accept = 1'b1;
    tick();
    bus_t.mem_accept = 1'b0;
    bus_t.mem_done   = 1'b1;
    bus_t.mem_rdata  = 16'hCAFE;
    tick();
    bus_t.mem_done = 1'b0;
    bus_t.req = 3'b0;
    n_cmp++;
    if ({bus_t.ack, bus_t.rdata, bus_t.err}
        !== {3'b001, 16'hCAFE, 1'b0}) begin
      n_bad++;
      $display("FAIL t5_pre: got ack %b rdata %h err %b want 001 cafe 0",
               bus_t.ack, bus_t.rdata, bus_t.err);
    end
    tick();
    bus_t.req = 3'b001;
    tick();
    bus_t.req = 3'b000;
    bus_t.mem_accept = 1'b1;
    k = 0;
    got = 1'b0;
    while (k < 40 && !got) begin
      tick();
      bus_t.mem_accept = 1'b0;
      k++;
      if (bus_t.ack !== 3'b0) got = 1'b1;
    end
    n_cmp++;
    if (k !== 16) begin
      n_bad++;
      $display("FAIL t5_latency: got ack after %0d cycles want 16", k);
    end
    n_cmp++;
    if ({bus_t.ack, bus_t.rdata, bus_t.err, bus_t.mem_req}
        !== {3'b001, 16'h0, 1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL t5_ack: got ack %b rdata %h err %b mreq %b want 001 0 1 0",
               bus_t.ack, bus_t.rdata, bus_t.err, bus_t.mem_req);
    end
    tick();
    n_cmp++;
    if ({bus_t.err, bus_t.busy, bus.err} !== 3'b100) begin
      n_bad++;
      $display("FAIL t5_sticky: got err/busy/main_err %b want 100",
               {bus_t.err, bus_t.busy, bus.err});
    end
  endtask

  task automatic test_reset_mid();
    bus.addr[22 +: 22] = 22'h00555;
    bus.mask = 6'b00_11_00;
    bus.req = 3'b010;
    tick();
    bus.mem_accept = 1'b1;
    tick();
    bus.mem_accept = 1'b0;
    n_cmp++;
    if ({bus.busy, bus.mem_req} !== 2'b10) begin
      n_bad++;
      $display("FAIL t6_wait: got busy/mreq %b want 10",
               {bus.busy, bus.mem_req});
    end
    rst = 1'b1;
    bus.req = 3'b0;
    tick();
    rst = 1'b0;
    n_cmp++;
    if ({bus.busy, bus.ack, bus.mem_req, bus.mem_we, bus.mem_dqm, bus.err}
        !== 9'b0_000_0_0_11_0) begin
      n_bad++;
      $display("FAIL t6_ctrl: got %b want 000000110",
               {bus.busy, bus.ack, bus.mem_req, bus.mem_we,
                bus.mem_dqm, bus.err});
    end
    n_cmp++;
    if ({bus.mem_addr, bus.rdata, bus_t.err} !== 39'h0) begin
      n_bad++;
      $display("FAIL t6_data: got addr %h rdata %h t_err %b want 0 0 0",
               bus.mem_addr, bus.rdata, bus_t.err);
    end
    tick();
    n_cmp++;
    if ({bus.ack, bus.busy} !== 4'b0) begin
      n_bad++;
      $display("FAIL t6_noack: got ack/busy %b want 0000",
               {bus.ack, bus.busy});
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

  initial begin
    clear_inputs();
    test_reset();
    test_single_read();
    test_contention();
    test_write_mask();
    test_accept_done_same();
    test_accept_stall();
    test_timeout();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
